// File: rtl/irq_controller.sv
// Prioritised interrupt controller feeding the MCU irq/irq_addr inputs.
// Sources are synchronised, latched as pending flags, masked by an
// I/O-mapped enable register, and the lowest-index active source is
// presented with its vector address until the CPU acknowledges it.
// Optional build macro: IRQ_CTL_LEVEL_EN (level-sensitive sources).
module irq_controller #(
  parameter int          N        = 8,
  parameter logic [15:0] VEC_BASE = 16'h0002,
  parameter int          VEC_STEP = 2,
  parameter logic [7:0]  ADDR_MSK = 8'h3B,
  parameter logic [7:0]  ADDR_FLG = 8'h3C
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N-1:0]  irq_src,
  input  logic          irq_ack,
  input  logic [7:0]    io_addr,
  input  logic          io_re,
  input  logic          io_we,
  input  logic [7:0]    io_wdata,
  output logic [7:0]    io_rdata,
  output logic          irq,
  output logic [15:0]   irq_addr,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_irq, w_irq_nxt;
  logic [15:0]   r_irq_addr, w_addr_nxt;
  logic [3:0]    r_cur_idx, w_idx_nxt;

  logic [N-1:0]  r_sync1, r_sync2;
  logic [N-1:0]  r_mask;
  logic [N-1:0]  w_flag, w_active;
  logic [N-1:0]  w_wdata_n;
  logic [15:0]   w_wdata_ext, w_mask_ext, w_flag_ext, w_cur_1h;
  logic          w_mask_we, w_flag_we, w_any, w_cur_active;
  logic [3:0]    w_sel_idx;
  logic [15:0]   w_sel_vec;

  assign w_mask_we   = io_we && (io_addr == ADDR_MSK);
  assign w_flag_we   = io_we && (io_addr == ADDR_FLG);
  // Only the low 8 bits are reachable from the byte-wide bus; higher
  // source bits see zeros, so their mask stays 0 and W1C never hits them.
  assign w_wdata_ext = {8'h00, io_wdata};
  assign w_wdata_n   = w_wdata_ext[N-1:0];

  // Two-flop synchroniser for the asynchronous sources
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  // Enable-mask register, written from the I/O bus
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_mask <= '0;
    else if (w_mask_we) r_mask <= w_wdata_n;
  end

  assign w_cur_1h = 16'h0001 << r_cur_idx;

`ifdef IRQ_CTL_LEVEL_EN
  // Level mode: the pending flag is simply the synchronised source level.
  assign w_flag = r_sync2;
`else
  logic [N-1:0] r_sync3, r_flag, w_edge, w_clr, w_ack_clr;
  assign w_edge    = r_sync2 & ~r_sync3;
  assign w_ack_clr = (r_state == S_REQ && irq_ack) ? w_cur_1h[N-1:0] : '0;
  assign w_clr     = (w_flag_we ? w_wdata_n : '0) | w_ack_clr;

  // Edge detect and pending flags; a fresh edge wins over any clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync3 <= '0;
      r_flag  <= '0;
    end else begin
      r_sync3 <= r_sync2;
      r_flag  <= w_edge | (r_flag & ~w_clr);
    end
  end
  assign w_flag = r_flag;
`endif

  assign w_active     = w_flag & r_mask;
  assign w_cur_active = |(w_active & w_cur_1h[N-1:0]);

  // Zero-extend mask/flags to 16 bits so any N maps onto the read byte
  always_comb begin
    w_mask_ext         = '0;
    w_flag_ext         = '0;
    w_mask_ext[N-1:0]  = r_mask;
    w_flag_ext[N-1:0]  = w_flag;
  end

  // Register read mux; side-effect free
  always_comb begin
    io_rdata = 8'h00;
    if (io_re && io_addr == ADDR_MSK)      io_rdata = w_mask_ext[7:0];
    else if (io_re && io_addr == ADDR_FLG) io_rdata = w_flag_ext[7:0];
  end

  // Priority encoder: lowest active index wins
  always_comb begin
    w_any     = |w_active;
    w_sel_idx = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_active[i]) w_sel_idx = 4'(i);
    end
    w_sel_vec = VEC_BASE + ({12'h000, w_sel_idx} * 16'(VEC_STEP));
  end

  // FSM state and registered request outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_irq      <= 1'b0;
      r_irq_addr <= 16'h0000;
      r_cur_idx  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq      <= w_irq_nxt;
      r_irq_addr <= w_addr_nxt;
      r_cur_idx  <= w_idx_nxt;
    end
  end

  // FSM next state: present, hold until ack/withdraw, one low gap cycle
  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_addr_nxt  = r_irq_addr;
    w_idx_nxt   = r_cur_idx;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_idx_nxt   = w_sel_idx;
          w_addr_nxt  = w_sel_vec;
          w_irq_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          w_irq_nxt   = 1'b0;
          w_state_nxt = S_GAP;
        end else if (!w_cur_active) begin
          w_irq_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        w_irq_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_irq_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign irq       = r_irq;
  assign irq_addr  = r_irq_addr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller (default edge-triggered build, N=8).
// Valid/ready note: the request side is irq (valid) / irq_ack (taken);
// the vector is compared once per rising edge of irq.
module tb_irq_controller;

  localparam logic [7:0] ADDR_MSK = 8'h3B;
  localparam logic [7:0] ADDR_FLG = 8'h3C;

  logic        clock;
  logic        reset_n;
  logic [7:0]  irq_src;
  logic        irq_ack;
  logic [7:0]  io_addr;
  logic        io_re;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        irq;
  logic [15:0] irq_addr;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prev_irq = 1'b0;
  logic [7:0]  rd;

  irq_controller dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .irq_src   (irq_src),
    .irq_ack   (irq_ack),
    .io_addr   (io_addr),
    .io_re     (io_re),
    .io_we     (io_we),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .irq       (irq),
    .irq_addr  (irq_addr),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] vec_of(input int idx);
    return 16'h0002 + 16'(idx * 2);
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    io_addr  = addr;
    io_wdata = data;
    io_we    = 1'b1;
    tick(1);
    io_we    = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] data);
    io_addr = addr;
    io_re   = 1'b1;
    #1;
    data    = io_rdata;
    io_re   = 1'b0;
  endtask

  task automatic pulse_src(input int idx);
    irq_src[idx] = 1'b1;
    tick(1);
    irq_src[idx] = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (irq !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (irq !== 1'b1) check("irq_timeout", {15'b0, irq}, 16'h0001);
  endtask

  // scoreboard: compare the vector at every new presentation
  always @(negedge clock) begin
    if (irq && !prev_irq) begin
      if (exp_q.size() == 0) check("unexpected_vec", irq_addr, 16'h0000);
      else check("vector", irq_addr, exp_q.pop_front());
    end
    prev_irq = irq;
  end

  initial begin
    reset_n = 1'b0; irq_src = 8'hFF; irq_ack = 1'b0;
    io_addr = 8'h00; io_re = 1'b0; io_we = 1'b0; io_wdata = 8'h00;

    // reset with all sources high
    tick(3);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    check("rst_addr", irq_addr, 16'h0000);
    check("rst_state", {14'b0, dbg_state}, 16'h0000);
    io_read(ADDR_MSK, rd); check("rst_mask", {8'h00, rd}, 16'h0000);
    io_read(ADDR_FLG, rd); check("rst_flag", {8'h00, rd}, 16'h0000);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    io_read(ADDR_FLG, rd); check("post_rst_flag", {8'h00, rd}, 16'h00FF);
    check("post_rst_irq", {15'b0, irq}, 16'h0000);
    irq_src = 8'h00;
    tick(4);
    io_write(ADDR_FLG, 8'hFF);
    io_read(ADDR_FLG, rd); check("w1c_all", {8'h00, rd}, 16'h0000);

    // mask readback and read gating
    io_write(ADDR_MSK, 8'h5A);
    io_read(ADDR_MSK, rd); check("mask_rb", {8'h00, rd}, 16'h005A);
    io_addr = ADDR_MSK; io_re = 1'b0; #1;
    check("rd_no_re", {8'h00, io_rdata}, 16'h0000);
    io_read(8'h3D, rd); check("rd_other_addr", {8'h00, rd}, 16'h0000);

    // single source through to ack
    io_write(ADDR_MSK, 8'h08);
    exp_q.push_back(vec_of(3));
    pulse_src(3);
    wait_irq(8);
    ack();
    check("ack_irq_low", {15'b0, irq}, 16'h0000);
    io_read(ADDR_FLG, rd); check("ack_flag_clr", {8'h00, rd}, 16'h0000);
    tick(3);

    // simultaneous sources: lower index first
    io_write(ADDR_MSK, 8'hFF);
    exp_q.push_back(vec_of(2));
    exp_q.push_back(vec_of(5));
    irq_src = 8'h24;
    wait_irq(8);
    ack();
    wait_irq(8);
    ack();
    irq_src = 8'h00;
    tick(4);

    // no preemption while a request is held
    exp_q.push_back(vec_of(4));
    irq_src[4] = 1'b1;
    wait_irq(8);
    exp_q.push_back(vec_of(0));
    irq_src[0] = 1'b1;
    tick(6);
    check("hold_addr", irq_addr, 16'h000A);
    check("hold_irq", {15'b0, irq}, 16'h0001);
    ack();
    wait_irq(8);
    ack();
    irq_src = 8'h00;
    tick(4);

    // withdraw by W1C while presented
    exp_q.push_back(vec_of(1));
    pulse_src(1);
    wait_irq(8);
    io_write(ADDR_FLG, 8'h02);
    tick(1);
    check("withdraw_irq", {15'b0, irq}, 16'h0000);
    check("withdraw_state", {14'b0, dbg_state}, 16'h0000);
    tick(4);
    io_read(ADDR_FLG, rd); check("withdraw_flag", {8'h00, rd}, 16'h0000);

    // edge and W1C on the same bit in the same cycle
    io_write(ADDR_MSK, 8'h00);
    irq_src[6] = 1'b1;
    tick(2);
    io_write(ADDR_FLG, 8'h40);
    irq_src[6] = 1'b0;
    io_read(ADDR_FLG, rd); check("set_beats_clr", {8'h00, rd}, 16'h0040);
    ack();
    io_read(ADDR_FLG, rd); check("ack_idle_ignored", {8'h00, rd}, 16'h0040);
    io_write(ADDR_FLG, 8'h40);
    io_read(ADDR_FLG, rd); check("w1c_bit6", {8'h00, rd}, 16'h0000);

    // random single-source requests
    io_write(ADDR_MSK, 8'hFF);
    for (int k = 0; k < 6; k++) begin
      int idx;
      idx = $urandom_range(0, 7);
      exp_q.push_back(vec_of(idx));
      pulse_src(idx);
      wait_irq(8);
      ack();
      tick(3);
      io_read(ADDR_FLG, rd); check("rand_flag_clr", {8'h00, rd}, 16'h0000);
    end

    // reset in the middle of a request
    exp_q.push_back(vec_of(2));
    pulse_src(2);
    wait_irq(8);
    tick(3);
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", {15'b0, irq}, 16'h0000);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    io_read(ADDR_FLG, rd); check("rst_flags_lost", {8'h00, rd}, 16'h0000);
    io_read(ADDR_MSK, rd); check("rst_mask_clr", {8'h00, rd}, 16'h0000);
    check("rst_state_idle", {14'b0, dbg_state}, 16'h0000);

    tick(2);
    check("exp_q_left", 16'(exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Prioritised interrupt controller sitting directly upstream of the MCU. It feeds the MCU `irq` / `irq_addr` inputs.
- Collects N external interrupt sources, latches them as pending flags and masks them with an I/O-mapped enable register.
- Presents the highest-priority request with its vector address, holding it until the CPU acknowledges.
- Mask and flag registers sit on the CPU I/O register bus, alongside the I/O register block.

Parameters:
N, 8, number of interrupt sources (1..16)
VEC_BASE, 16'h0002, program-word address of the vector for source 0
VEC_STEP, 2, program words between consecutive vectors
ADDR_MSK, 8'h3B, I/O address of enable-mask register
ADDR_FLG, 8'h3C, I/O address of pending-flag register

Ports:
clock  input  1  master clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
irq_src  input  N  raw external interrupt sources; asynchronous to clock
irq_ack  input  1  one-cycle pulse from CPU when it takes the vector
io_addr  input  8  I/O register address
io_re  input  1  I/O read enable
io_we  input  1  I/O write enable
io_wdata  input  8  I/O write data
io_rdata  output  8  I/O read data; 0 when address does not match
irq  output  1  interrupt request to MCU
irq_addr  output  16  vector address of the presented request

Behaviour:
- Reset (reset_n low, asynchronous): all state cleared; fsm=IDLE.
  - Zero: sync flops, mask, flags, cur_idx, irq, irq_addr.
  - io_rdata=0 (combinational, so it follows reset state).
- Synchroniser: irq_src passes through 2 flops per bit, then a third flop for edge detect.
- Flag set: a synchronised rising edge sets flag[i]. Latency from irq_src rise to flag set is 3 clocks.
- Mask register: written when io_we && io_addr==ADDR_MSK; bits [N-1:0] = io_wdata. Bits at or above N are ignored.
- Flag register: write-1-to-clear when io_we && io_addr==ADDR_FLG.
- Register reads: io_rdata = zero-extended mask or flags when io_re and the address matches; otherwise 0. Reads never alter state.
- Flag priority, same bit, same cycle:
  - Set (edge) beats any clear, so a new event is never lost.
  - Ack-clear together with W1C gives cleared.
- Request selection: active = flag & mask. Lowest index has highest priority. For N>8, the upper mask/flag bits are not I/O-accessible and reset to 0; the mask for those bits stays 0.
- FSM:
  - IDLE: if active!=0, capture cur_idx = lowest set bit. Next clock: irq=1, irq_addr = VEC_BASE + cur_idx*VEC_STEP (16-bit, wraps modulo 2^16). Go to REQ.
  - REQ: irq and irq_addr held stable; no preemption by higher-priority arrivals.
    - On irq_ack: clear flag[cur_idx], drive irq=0, go to GAP.
    - If active[cur_idx] drops (mask cleared or W1C) with no ack in that cycle: irq=0, go to IDLE (withdrawn request).
    - Ack and withdraw in the same cycle: treated as ack.
  - GAP: one cycle with irq=0, so the MCU register stage sees a low, then IDLE. A still-pending source is re-presented earliest 2 clocks after ack.
- irq_ack while in IDLE or GAP: ignored.
- Reset asserted mid-request: irq drops immediately (asynchronous); all pending flags are lost.
- Minimum latency: flag set to irq high is 1 clock.

Optional Feature:
Macro IRQ_CTL_LEVEL_EN.
- Defined: sources are level-sensitive.
  - flag[i] = synchronised irq_src[i], 2 clocks latency; the edge-detect flop is not built.
  - W1C writes and irq_ack do not clear flags; the flag register reads the synchronised levels.
  - A source that deasserts while in REQ withdraws the request per the rule above.
- Undefined: edge-triggered latching as described in Behaviour.

Test Plan:
- Reset with irq_src=8'hFF held -> irq=0, irq_addr=0, mask and flag read 0. After release with mask=0: flag reads 8'hFF (edge only if sources rise after reset; start sources low), irq stays 0.
- Mask=8'h08, pulse irq_src[3] for 1 clock -> irq=1, irq_addr=16'h0008 within 5 clocks. Pulse irq_ack -> irq=0 next clock, flag reads 8'h00.
- Mask=8'hFF, raise src[5] and src[2] in the same cycle -> vector 16'h0006 first. After ack plus GAP -> vector 16'h000C.
- In REQ for src[4], raise src[0] -> irq_addr stays 16'h000A until ack, then 16'h0002 is presented.
- In REQ for src[1], write ADDR_FLG=8'h02 -> irq=0 the next clock, FSM returns to IDLE, no vector presented.
- Same cycle: synchronised edge on src[6] and W1C of bit 6 -> flag[6] stays 1. With IRQ_CTL_LEVEL_EN: src[6] held high survives ack and W1C, and is re-presented after GAP.
